// File: rtl/simd_vec_engine_pkg.sv
// Shared definitions for the SIMD vector engine.
// Holds the per-lane opcode encodings and the controller state encoding.
// Imported by the lane ALU, the top-level engine and the testbench.
package simd_pkg;

    // Per-lane opcodes carried on the 3-bit instruction field
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_MIN = 3'b110;
    localparam logic [2:0] OP_MAX = 3'b111;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD,
        ST_CALC,
        ST_OUT,
        ST_FIN
    } state_t;

endpackage

// File: rtl/simd_vec_engine_if.sv
// Host/collector bus of the SIMD vector engine.
// Groups the instruction strobe, operand-row handshake, result stream and
// status flags. The master modport is the host/collector side, the slave
// modport is the engine side.
//   valid_instruction/instruction/sat_mode/lane_mask/data_size : instruction
//   valid_data/data_ready/data_in_opa/data_in_opb              : operand rows
//   out_valid/out_ready/out_result/out_extra/out_last          : result rows
//   busy/done/error                                            : status
interface simd_vec_engine_if #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 32,
    parameter int DEPTH     = 64
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int VEC_W  = NUM_LANES * LANE_W;

    logic                 valid_instruction;
    logic [2:0]           instruction;
    logic                 sat_mode;
    logic [NUM_LANES-1:0] lane_mask;
    logic [ADDR_W:0]      data_size;
    logic                 valid_data;
    logic                 data_ready;
    logic [VEC_W-1:0]     data_in_opa;
    logic [VEC_W-1:0]     data_in_opb;
    logic                 out_valid;
    logic                 out_ready;
    logic [VEC_W-1:0]     out_result;
    logic [VEC_W-1:0]     out_extra;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output valid_instruction, instruction, sat_mode, lane_mask, data_size,
        output valid_data, data_in_opa, data_in_opb, out_ready,
        input  data_ready, out_valid, out_result, out_extra, out_last,
        input  busy, done, error
    );

    modport slave (
        input  valid_instruction, instruction, sat_mode, lane_mask, data_size,
        input  valid_data, data_in_opa, data_in_opb, out_ready,
        output data_ready, out_valid, out_result, out_extra, out_last,
        output busy, done, error
    );

endinterface

// File: rtl/simd_vec_engine_lane_alu.sv
// One combinational lane of the SIMD engine.
// Ports:
//   a, b    : lane operands
//   opcode  : operation select (see simd_pkg)
//   sat     : signed saturation for ADD/SUB
//   en      : lane enable; a disabled lane outputs zero result and extra
//   result  : lane result
//   extra   : bit0 carry/borrow (ADD/SUB), bit1 saturation flag,
//             or the high product word for MUL
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int LANE_W = 32
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic [2:0]        opcode,
    input  logic              sat,
    input  logic              en,
    output logic [LANE_W-1:0] result,
    output logic [LANE_W-1:0] extra
);

    logic [LANE_W:0]     sum;
    logic [LANE_W:0]     diff;
    logic [2*LANE_W-1:0] prod;
    logic                add_ovf;
    logic                sub_ovf;
    logic [LANE_W-1:0]   sat_val;

    // Signed overflow is detected from operand/result sign bits; the clamp
    // value follows the sign of A since an overflow always pushes the result
    // past the limit on A's side.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        prod    = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
        add_ovf = (a[LANE_W-1] == b[LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1]);
        sub_ovf = (a[LANE_W-1] != b[LANE_W-1]) && (diff[LANE_W-1] != a[LANE_W-1]);
        sat_val = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        result  = '0;
        extra   = '0;
        case (opcode)
            OP_ADD: begin
                result   = sum[LANE_W-1:0];
                extra[0] = sum[LANE_W];
                if (sat && add_ovf) begin
                    result   = sat_val;
                    extra[1] = 1'b1;
                end
            end
            OP_SUB: begin
                result   = diff[LANE_W-1:0];
                extra[0] = diff[LANE_W];
                if (sat && sub_ovf) begin
                    result   = sat_val;
                    extra[1] = 1'b1;
                end
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MUL: begin
                result = prod[LANE_W-1:0];
                extra  = prod[2*LANE_W-1:LANE_W];
            end
            OP_MIN: result = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX: result = ($signed(a) > $signed(b)) ? a : b;
            default: ;
        endcase
        if (!en) begin
            result = '0;
            extra  = '0;
        end
    end

endmodule

// File: rtl/simd_vec_engine.sv
// SIMD vector engine: buffers up to DEPTH rows of packed operand pairs, then
// runs one opcode across NUM_LANES lanes of LANE_W bits, streaming one result
// row at a time with an end-of-vector marker.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : engine side of simd_vec_engine_if (instruction, operand rows,
//           result stream, busy/done/error status)
// Lane i occupies bits [(NUM_LANES-i)*LANE_W-1 -: LANE_W]; lane_mask follows
// the same MSB-first order, so lane i is enabled by lane_mask[NUM_LANES-1-i].
module simd_vec_engine
    import simd_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 32,
    parameter int DEPTH     = 64
) (
    input logic              clk,
    input logic              reset,
    simd_vec_engine_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int VEC_W  = NUM_LANES * LANE_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [2:0]           opcode_q, opcode_d;
    logic                 sat_q, sat_d;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic                 error_q, error_d;
    logic [VEC_W-1:0]     out_result_q, out_result_d;
    logic [VEC_W-1:0]     out_extra_q, out_extra_d;
    logic                 out_last_q, out_last_d;
    logic                 wr_en;

    logic [2*VEC_W-1:0]   row_mem [DEPTH];
    logic [2*VEC_W-1:0]   row_q;
    logic [VEC_W-1:0]     opa, opb;
    logic [VEC_W-1:0]     lane_res, lane_ext;

    assign opa = row_q[2*VEC_W-1 -: VEC_W];
    assign opb = row_q[VEC_W-1:0];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .a      (opa[(NUM_LANES-i)*LANE_W-1 -: LANE_W]),
            .b      (opb[(NUM_LANES-i)*LANE_W-1 -: LANE_W]),
            .opcode (opcode_q),
            .sat    (sat_q),
            .en     (mask_q[NUM_LANES-1-i]),
            .result (lane_res[(NUM_LANES-i)*LANE_W-1 -: LANE_W]),
            .extra  (lane_ext[(NUM_LANES-i)*LANE_W-1 -: LANE_W])
        );
    end

    // Next-state and datapath control. The instruction fields are only
    // captured in IDLE, so a strobe arriving mid-vector has no effect.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        opcode_d     = opcode_q;
        sat_d        = sat_q;
        mask_d       = mask_q;
        error_d      = 1'b0;
        out_result_d = out_result_q;
        out_extra_d  = out_extra_q;
        out_last_d   = out_last_q;
        wr_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid_instruction) begin
                    opcode_d = bus.instruction;
                    sat_d    = bus.sat_mode;
                    mask_d   = bus.lane_mask;
                    count_d  = bus.data_size;
                    if (bus.data_size == '0 || bus.data_size > DEPTH_CNT) begin
                        error_d = 1'b1;
                    end else begin
                        wr_ptr_d = '0;
                        state_d  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.valid_data) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if ({1'b0, wr_ptr_q} == count_q - ONE_CNT) begin
                        rd_ptr_d = '0;
                        state_d  = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                out_result_d = lane_res;
                out_extra_d  = lane_ext;
                out_last_d   = ({1'b0, rd_ptr_q} == count_q - ONE_CNT);
                state_d      = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        state_d = ST_FIN;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        state_d  = ST_RD;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers; reset abandons any vector in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            opcode_q     <= OP_ADD;
            sat_q        <= 1'b0;
            mask_q       <= '0;
            error_q      <= 1'b0;
            out_result_q <= '0;
            out_extra_q  <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            opcode_q     <= opcode_d;
            sat_q        <= sat_d;
            mask_q       <= mask_d;
            error_q      <= error_d;
            out_result_q <= out_result_d;
            out_extra_q  <= out_extra_d;
            out_last_q   <= out_last_d;
        end
    end

    // Operand buffer with registered read; kept reset-free so it maps onto
    // block RAM. row_q is the RAM output register, loaded only in RD.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            row_mem[wr_ptr_q] <= {bus.data_in_opa, bus.data_in_opb};
        end
        if (state_q == ST_RD) begin
            row_q <= row_mem[rd_ptr_q];
        end
    end

    assign bus.data_ready = (state_q == ST_LOAD);
    assign bus.out_valid  = (state_q == ST_OUT);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_FIN);
    assign bus.error      = error_q;
    assign bus.out_result = out_result_q;
    assign bus.out_extra  = out_extra_q;
    assign bus.out_last   = out_last_q;

endmodule
